// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the serial pattern detector: the FSM state enum
//   and the 2-bit encodings driven on the debug state output.
//   No ports (package).
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } det_state_e;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_FILL    = FILL;
  localparam logic [1:0] ST_ARMED   = ARMED;
  // Unused encoding; the FSM falls back to IDLE if it ever lands here.
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector_if
//   Bundles the data, config and status signals of seq_pattern_detector.
//   Ports (as signals):
//     en, din_valid, din        - serial input and its qualifiers
//     cfg_we, cfg_pattern,
//     cfg_len, cfg_overlap      - config write strobe and payload
//     cnt_clr                   - synchronous match counter clear
//     match, match_cnt,
//     cfg_err, state            - detector outputs
//   Modports: master drives inputs / observes outputs, slave is the detector.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);

  logic               en;
  logic               din_valid;
  logic               din;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;
  logic [1:0]         state;

  modport master (
    output en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_cnt, cfg_err, state
  );

  modport slave (
    input  en, din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_cnt, cfg_err, state
  );

endinterface

// File: rtl/seq_match_counter.sv
// seq_match_counter
//   Saturating up-counter for detected matches.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     inc       - count one match this cycle
//     clr       - synchronous clear; clr together with inc yields 1
//     cnt       - current count, saturates at all-ones
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A clear in the same cycle as a match still records that match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Runtime-programmable serial bit-pattern detector (up to MAX_LEN bits),
//   overlapping or non-overlapping, with a registered one-cycle match pulse,
//   saturating match counter and sticky config error flag.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     bus       - seq_pattern_detector_if.slave (data, config, status)
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN = 8,
  parameter int               LW      = $clog2(MAX_LEN + 1),
  parameter int               CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(8'b0000_1011),
  parameter logic [LW-1:0]    LEN_RST = LW'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_pattern_detector_if.slave bus
);

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LW-1:0]      len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      hcnt_q, hcnt_d;
  logic [1:0]         state_q, state_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LW-1:0]      hcnt_inc;
  logic               hit;
  logic               take;
  logic               cfg_legal;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
  end

  always_comb begin
    hist_shift = (hist_q << 1) | MAX_LEN'(bus.din);
    hcnt_inc   = (hcnt_q < len_q) ? hcnt_q + LW'(1) : hcnt_q;
    hit        = ((hist_shift & len_mask) == (pat_q & len_mask)) && (hcnt_inc >= len_q);
    // A config write in the same cycle swallows the incoming bit.
    take       = bus.en && bus.din_valid && !bus.cfg_we && (state_q != ST_ILLEGAL);
    cfg_legal  = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cfg_err_d = cfg_err_q;
    match_d   = 1'b0;

    if (!bus.en || (state_q == ST_ILLEGAL)) begin
      state_d = ST_IDLE;
      hist_d  = '0;
      hcnt_d  = '0;
    end else if (take) begin
      match_d = hit;
      if (hit && !ovl_q) begin
        // Non-overlapping: the matched bits cannot start the next pattern.
        state_d = ST_FILL;
        hist_d  = '0;
        hcnt_d  = '0;
      end else begin
        hist_d  = hist_shift;
        hcnt_d  = hcnt_inc;
        state_d = (hcnt_inc >= len_q) ? ST_ARMED : ST_FILL;
      end
    end else if (state_q == ST_IDLE) begin
      state_d = ST_FILL;
    end

    // An illegal write only raises the flag; everything else carries on.
    if (bus.cfg_we) begin
      if (cfg_legal) begin
        pat_d     = bus.cfg_pattern;
        len_d     = bus.cfg_len;
        ovl_d     = bus.cfg_overlap;
        hist_d    = '0;
        hcnt_d    = '0;
        state_d   = bus.en ? ST_FILL : ST_IDLE;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= PAT_RST;
      len_q     <= LEN_RST;
      ovl_q     <= 1'b1;
      hist_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= ST_IDLE;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .inc (match_d),
    .clr (bus.cnt_clr),
    .cnt (bus.match_cnt)
  );

  assign bus.match   = match_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector
//   Scoreboard bench for seq_pattern_detector. Two detectors share the same
//   stimulus: dut_a with an 8-bit counter and dut_b with a 2-bit counter.
//   Expected match counts are queued as bits are issued; a monitor pops one
//   entry for every cycle in which match is high.
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];

  seq_pattern_detector_if #(.MAX_LEN(8), .CNT_W(8)) ifa ();
  seq_pattern_detector_if #(.MAX_LEN(8), .CNT_W(2)) ifb ();

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  assign ifb.en          = ifa.en;
  assign ifb.din_valid   = ifa.din_valid;
  assign ifb.din         = ifa.din;
  assign ifb.cfg_we      = ifa.cfg_we;
  assign ifb.cfg_pattern = ifa.cfg_pattern;
  assign ifb.cfg_len     = ifa.cfg_len;
  assign ifb.cfg_overlap = ifa.cfg_overlap;
  assign ifb.cnt_clr     = ifa.cnt_clr;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issue one accepted bit; if it should complete a match, queue the counts.
  task automatic apply_stimulus(input logic b, input logic exp_match, input int exp_cnt,
                                input logic clr);
    exp_t e;
    ifa.din_valid = 1'b1;
    ifa.din       = b;
    ifa.cnt_clr   = clr;
    if (exp_match) begin
      e.cnt8 = 8'(exp_cnt);
      e.cnt2 = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    ifa.din_valid = 1'b0;
    ifa.cnt_clr   = 1'b0;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    ifa.cfg_we      = 1'b1;
    ifa.cfg_pattern = pat;
    ifa.cfg_len     = len;
    ifa.cfg_overlap = ovl;
    @(posedge clk);
    #1;
    ifa.cfg_we = 1'b0;
  endtask

  task automatic clear_cnt();
    ifa.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    ifa.cnt_clr = 1'b0;
    check_output("cnt_clr_alone", int'(ifa.match_cnt), 0);
  endtask

  // One idle cycle lets the monitor see the last pulse, then confirm nothing is pending.
  task automatic end_test(input string name, input int exp_cnt);
    @(posedge clk);
    #1;
    check_output({name, "_pending"}, sb.size(), 0);
    check_output({name, "_match_low"}, int'(ifa.match), 0);
    check_output({name, "_cnt"}, int'(ifa.match_cnt), exp_cnt);
    sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ifa.match === 1'b1)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_match: got match=1 cnt=%0d expected no match",
                 ifa.match_cnt);
      end else begin
        e = sb.pop_front();
        if ((ifa.match_cnt !== e.cnt8) || (ifb.match_cnt !== e.cnt2) || (ifb.match !== 1'b1)) begin
          bad++;
          $display("[TB] FAIL match_cnt: got a=%0d b=%0d b_match=%0b expected a=%0d b=%0d b_match=1",
                   ifa.match_cnt, ifb.match_cnt, ifb.match, e.cnt8, e.cnt2);
        end
      end
    end
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst             = 1'b1;
    ifa.en          = 1'b0;
    ifa.din_valid   = 1'b0;
    ifa.din         = 1'b0;
    ifa.cfg_we      = 1'b0;
    ifa.cfg_pattern = '0;
    ifa.cfg_len     = '0;
    ifa.cfg_overlap = 1'b0;
    ifa.cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_match", int'(ifa.match), 0);
    check_output("rst_cnt", int'(ifa.match_cnt), 0);
    check_output("rst_cfg_err", int'(ifa.cfg_err), 0);
    check_output("rst_state", int'(ifa.state), int'(ST_IDLE));
    rst    = 1'b0;
    ifa.en = 1'b1;
    @(posedge clk);
    #1;
    check_output("idle_to_fill", int'(ifa.state), int'(ST_FILL));

    $display("[TB] reset pattern 1011 overlapping");
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    check_output("fill_state", int'(ifa.state), int'(ST_FILL));
    apply_stimulus(1'b1, 1'b1, 1, 1'b0);
    check_output("armed_state", int'(ifa.state), int'(ST_ARMED));
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0);
    end_test("ovl_1011", 2);

    $display("[TB] 1011 non-overlapping");
    configure(8'b1011, 4'd4, 1'b0);
    clear_cnt();
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1, 1'b0);
    check_output("novl_refill_state", int'(ifa.state), int'(ST_FILL));
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    end_test("novl_1011", 1);

    $display("[TB] single-bit pattern");
    configure(8'b1, 4'd1, 1'b1);
    clear_cnt();
    apply_stimulus(1'b1, 1'b1, 1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 3, 1'b0);
    end_test("len1", 3);

    $display("[TB] counter saturation");
    clear_cnt();
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b1, i, 1'b0);
    end
    end_test("sat_a", 5);
    check_output("sat_b_cnt", int'(ifb.match_cnt), 3);
    apply_stimulus(1'b1, 1'b1, 1, 1'b1);
    end_test("clr_with_match", 1);
    check_output("clr_with_match_b", int'(ifb.match_cnt), 1);

    $display("[TB] illegal then legal config");
    configure(8'b1011, 4'd4, 1'b1);
    clear_cnt();
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    configure(8'b0110, 4'd0, 1'b0);
    check_output("cfg_err_set", int'(ifa.cfg_err), 1);
    check_output("cfg_err_state", int'(ifa.state), int'(ST_FILL));
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1, 1'b0);
    configure(8'b110, 4'd3, 1'b1);
    check_output("cfg_err_clear", int'(ifa.cfg_err), 0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2, 1'b0);
    end_test("cfg", 2);

    $display("[TB] reset mid-stream");
    configure(8'b1011, 4'd4, 1'b1);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_output("midrst_match", int'(ifa.match), 0);
    check_output("midrst_cnt", int'(ifa.match_cnt), 0);
    check_output("midrst_state", int'(ifa.state), int'(ST_IDLE));
    @(posedge clk);
    #1;
    check_output("midrst_cfg_err", int'(ifa.cfg_err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1, 1'b0);
    end_test("post_rst", 1);

    $display("[TB] enable drop after match");
    configure(8'b1, 4'd1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0);
    ifa.en = 1'b0;
    @(posedge clk);
    #1;
    check_output("en_drop_state", int'(ifa.state), int'(ST_IDLE));
    ifa.en = 1'b1;
    end_test("en_drop", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
